tacometro_pulsos: RTL and testbench

- Sensor pulse counter (tachometer) that consumes the 1-cycle gate strobe from the clock-divider enable generator.
- Counts rising edges of the asynchronous motor speed sensor (optical or Hall) over each gate window.
- Publishes the count once per window with a 1-cycle valid pulse. Downstream speed control and display logic read this count as pulses-per-window.

---
 rtl/tacometro_pulsos_if.sv | 26 ++
 rtl/tacometro_pulsos.sv | 138 +++++++++++++
 tb/tb_tacometro_pulsos.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tacometro_pulsos_if.sv
// Tachometer measurement bus: enable/gate/sensor inputs and count results.
// Ports: en, gate_stb, sensor_in (master -> slave);
//        count_out, count_valid, overflow, measuring (slave -> master).
interface tacometro_pulsos_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             gate_stb;
  logic             sensor_in;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             overflow;
  logic             measuring;

  // master: controller that drives the window and reads results
  modport master (
    output en, gate_stb, sensor_in,
    input  count_out, count_valid, overflow, measuring
  );

  // slave: the tachometer itself
  modport slave (
    input  en, gate_stb, sensor_in,
    output count_out, count_valid, overflow, measuring
  );
endinterface

// File: rtl/tacometro_pulsos.sv
// Counts debounced rising edges of an async sensor per gate window, publishes count once per window.
// Latency: count_valid one cycle after gate_stb; sensor edge to filtered level 2+DEB_CYCLES cycles.
// Backpressure: none; count_valid is a 1-cycle pulse the consumer must sample on that cycle.
// Ports: clk_in, rst (sync, active-high); bus (slave modport): en, gate_stb, sensor_in in;
//        count_out, count_valid, overflow, measuring out.
module tacometro_pulsos #(
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  tacometro_pulsos_if.slave bus
);

  typedef enum logic {
    WAIT_GATE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // synchronizer + debounce
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q, filt_d;
  logic             filt_dly_q, filt_dly_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             evt;

  // measurement FSM and results
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             count_valid_q, count_valid_d;
  logic             overflow_q, overflow_d;
  logic             measuring_q, measuring_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             sat_now;

  always_comb begin
    sync1_d    = bus.sensor_in;
    sync2_d    = sync1_q;
    filt_d     = filt_q;
    filt_dly_d = filt_q;
    deb_cnt_d  = '0;
    // The filtered level only follows sync2 after DEB_CYCLES consecutive disagreeing cycles.
    if (sync2_q != filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        filt_d    = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign evt = filt_q & ~filt_dly_q;

  always_comb begin
    // Count including this cycle's event, saturating at the maximum.
    sat_now = evt && (cnt_q == CNT_MAX);
    cnt_inc = (evt && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

    state_d       = state_q;
    cnt_d         = cnt_q;
    ovf_acc_d     = ovf_acc_q;
    count_out_d   = count_out_q;
    overflow_d    = overflow_q;
    count_valid_d = 1'b0;

    if (!bus.en) begin
      // Disable aborts the window in any state; published results hold.
      state_d   = WAIT_GATE;
      cnt_d     = '0;
      ovf_acc_d = 1'b0;
    end else if (state_q == WAIT_GATE) begin
      cnt_d     = '0;
      ovf_acc_d = 1'b0;
      if (bus.gate_stb) begin
        state_d = MEASURE;
      end
    end else begin
      if (bus.gate_stb) begin
        // An event on the gate cycle belongs to the window being closed.
        count_out_d   = cnt_inc;
        overflow_d    = ovf_acc_q | sat_now;
        count_valid_d = 1'b1;
        cnt_d         = '0;
        ovf_acc_d     = 1'b0;
      end else begin
        cnt_d     = cnt_inc;
        ovf_acc_d = ovf_acc_q | sat_now;
      end
    end

    measuring_d = (state_d == MEASURE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      filt_q        <= 1'b0;
      filt_dly_q    <= 1'b0;
      deb_cnt_q     <= '0;
      state_q       <= WAIT_GATE;
      cnt_q         <= '0;
      ovf_acc_q     <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      measuring_q   <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      filt_q        <= filt_d;
      filt_dly_q    <= filt_dly_d;
      deb_cnt_q     <= deb_cnt_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ovf_acc_q     <= ovf_acc_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      overflow_q    <= overflow_d;
      measuring_q   <= measuring_d;
    end
  end

  assign bus.count_out   = count_out_q;
  assign bus.count_valid = count_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.measuring   = measuring_q;

endmodule

// File: tb/tb_tacometro_pulsos.sv
// Testbench for tacometro_pulsos with CNT_W=8, DEB_CYCLES=2.
// Expected counts come from the number of clean pulses placed in each window, saturated.
module tb_tacometro_pulsos;
  localparam int CNT_W      = 8;
  localparam int DEB_CYCLES = 2;
  localparam int DEB_W      = 8;
  localparam int CMAX       = (1 << CNT_W) - 1;
  // Sensor high cycles needed so its edge event lines up with a gate on the next cycle.
  localparam int ALIGN      = DEB_CYCLES + 2;

  logic clk_in = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   nvalid   = 0;

  tacometro_pulsos_if #(.CNT_W(CNT_W)) bus ();

  tacometro_pulsos #(
    .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // One clock: inputs applied, edge, outputs sampled 1 time unit later.
  task automatic step(input logic s, input logic g);
    bus.sensor_in = s;
    bus.gate_stb  = g;
    @(posedge clk_in);
    #1;
    if (bus.count_valid === 1'b1) nvalid++;
  endtask

  // Emit n clean pulses, optional 1-cycle glitch in each low gap, then pad low.
  task automatic window(input int n, input int hi, input int lo, input int len, input bit glitch);
    int pad;
    for (int i = 0; i < n; i++) begin
      repeat (hi) step(1'b1, 1'b0);
      if (glitch && lo >= 5) begin
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (lo - 3) step(1'b0, 1'b0);
      end else begin
        repeat (lo) step(1'b0, 1'b0);
      end
    end
    pad = len - 1 - n * (hi + lo);
    if (pad < 6) pad = 6;
    repeat (pad) step(1'b0, 1'b0);
  endtask

  // Gate cycle, capture outputs after it and one cycle later.
  task automatic do_gate(output logic v, output logic [CNT_W-1:0] c, output logic o,
                         output logic v_next);
    step(1'b0, 1'b1);
    v = bus.count_valid;
    c = bus.count_out;
    o = bus.overflow;
    step(1'b0, 1'b0);
    v_next = bus.count_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    checks++; if (bus.count_out !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", bus.count_out); end
    checks++; if (bus.count_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.count_valid); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
    checks++; if (bus.measuring !== 1'b0) begin failures++; $display("FAIL reset_meas: got %b expected 0", bus.measuring); end
  endtask

  task automatic test_basic();
    logic v, o, vn; logic [CNT_W-1:0] c;
    rst = 1'b0; bus.en = 1'b1;
    step(1'b0, 1'b0);
    checks++; if (bus.measuring !== 1'b0) begin failures++; $display("FAIL basic_wait_meas: got %b expected 0", bus.measuring); end
    window(0, 10, 10, 100, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL basic_first_gate_valid: got %b expected 0", v); end
    checks++; if (bus.measuring !== 1'b1) begin failures++; $display("FAIL basic_meas: got %b expected 1", bus.measuring); end
    window(5, 10, 10, 100, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (v !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", v); end
    checks++; if (c !== 8'd5) begin failures++; $display("FAIL basic_count: got %0d expected 5", c); end
    checks++; if (o !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b expected 0", o); end
    checks++; if (vn !== 1'b0) begin failures++; $display("FAIL basic_valid_width: got %b expected 0", vn); end
  endtask

  task automatic test_glitch();
    logic v, o, vn; logic [CNT_W-1:0] c;
    for (int w = 0; w < 2; w++) begin
      window(3, 2, 6, 60, 1'b1);
      do_gate(v, c, o, vn);
      checks++; if (v !== 1'b1 || c !== 8'd3) begin failures++; $display("FAIL glitch_count[%0d]: got valid=%b count=%0d expected valid=1 count=3", w, v, c); end
    end
  endtask

  task automatic test_saturation();
    logic v, o, vn; logic [CNT_W-1:0] c;
    window(300, 2, 2, 1300, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (c !== 8'd255) begin failures++; $display("FAIL sat_count: got %0d expected 255", c); end
    checks++; if (o !== 1'b1) begin failures++; $display("FAIL sat_ovf: got %b expected 1", o); end
    window(4, 3, 3, 40, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (c !== 8'd4 || o !== 1'b0) begin failures++; $display("FAIL sat_next: got count=%0d ovf=%b expected count=4 ovf=0", c, o); end
  endtask

  task automatic test_gate_align();
    logic v, o, vn; logic [CNT_W-1:0] c;
    window(2, 4, 4, 20, 1'b0);
    repeat (ALIGN) step(1'b1, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (v !== 1'b1 || c !== 8'd3) begin failures++; $display("FAIL align_count: got valid=%b count=%0d expected valid=1 count=3", v, c); end
    window(0, 2, 2, 20, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (c !== 8'd0) begin failures++; $display("FAIL align_next: got %0d expected 0", c); end
  endtask

  task automatic test_enable();
    logic v, o, vn; logic [CNT_W-1:0] c;
    int nv0;
    window(7, 3, 3, 50, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (c !== 8'd7) begin failures++; $display("FAIL en_pre_count: got %0d expected 7", c); end
    window(2, 3, 3, 15, 1'b0);
    nv0 = nvalid;
    bus.en = 1'b0;
    step(1'b0, 1'b1); // en falling with gate: no valid
    checks++; if (bus.count_valid !== 1'b0) begin failures++; $display("FAIL en_gate_valid: got %b expected 0", bus.count_valid); end
    checks++; if (bus.measuring !== 1'b0) begin failures++; $display("FAIL en_meas: got %b expected 0", bus.measuring); end
    window(3, 3, 3, 30, 1'b0);
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    checks++; if (nvalid !== nv0) begin failures++; $display("FAIL en_no_valid: got %0d valids expected %0d", nvalid, nv0); end
    bus.en = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL en_first_gate: got %b expected 0", v); end
    window(4, 3, 3, 40, 1'b0);
    checks++; if (bus.count_out !== 8'd7) begin failures++; $display("FAIL en_hold: got %0d expected 7", bus.count_out); end
    do_gate(v, c, o, vn);
    checks++; if (v !== 1'b1 || c !== 8'd4) begin failures++; $display("FAIL en_count: got valid=%b count=%0d expected valid=1 count=4", v, c); end
  endtask

  task automatic test_reset_mid();
    logic v, o, vn; logic [CNT_W-1:0] c;
    window(2, 3, 3, 15, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0);
    checks++; if (bus.count_out !== '0 || bus.count_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.measuring !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs: got count=%0d valid=%b ovf=%b meas=%b expected all 0", bus.count_out, bus.count_valid, bus.overflow, bus.measuring);
    end
    rst = 1'b0;
    repeat (5) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL rstmid_first_gate: got %b expected 0", v); end
    window(2, 3, 3, 20, 1'b0);
    do_gate(v, c, o, vn);
    checks++; if (v !== 1'b1 || c !== 8'd2) begin failures++; $display("FAIL rstmid_count: got valid=%b count=%0d expected valid=1 count=2", v, c); end
  endtask

  task automatic test_back_to_back();
    logic v1, v2, v3; logic [CNT_W-1:0] c1, c2;
    window(1, 3, 3, 20, 1'b0);
    step(1'b0, 1'b1);
    v1 = bus.count_valid; c1 = bus.count_out;
    step(1'b0, 1'b1);
    v2 = bus.count_valid; c2 = bus.count_out;
    step(1'b0, 1'b0);
    v3 = bus.count_valid;
    checks++; if (v1 !== 1'b1 || c1 !== 8'd1) begin failures++; $display("FAIL b2b_first: got valid=%b count=%0d expected valid=1 count=1", v1, c1); end
    checks++; if (v2 !== 1'b1 || c2 !== 8'd0) begin failures++; $display("FAIL b2b_second: got valid=%b count=%0d expected valid=1 count=0", v2, c2); end
    checks++; if (v3 !== 1'b0) begin failures++; $display("FAIL b2b_after: got %b expected 0", v3); end
  endtask

  task automatic test_random();
    logic v, o, vn; logic [CNT_W-1:0] c;
    int n, hi, lo, exp_c;
    bit g, exp_o;
    for (int w = 0; w < 8; w++) begin
      if (w == 3) begin
        n = $urandom_range(256, 280); hi = 2; lo = 2; g = 1'b0;
      end else begin
        n = $urandom_range(0, 20); hi = $urandom_range(2, 5); lo = $urandom_range(2, 6); g = 1'($urandom_range(0, 1));
      end
      exp_c = (n > CMAX) ? CMAX : n;
      exp_o = (n > CMAX);
      window(n, hi, lo, n * (hi + lo) + $urandom_range(6, 15), g);
      do_gate(v, c, o, vn);
      checks++; if (v !== 1'b1 || c !== CNT_W'(exp_c) || o !== exp_o || vn !== 1'b0) begin
        failures++;
        $display("FAIL rand_window[%0d]: got valid=%b count=%0d ovf=%b next_valid=%b expected valid=1 count=%0d ovf=%b next_valid=0", w, v, c, o, vn, exp_c, exp_o);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.gate_stb = 1'b0;
    bus.sensor_in = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_saturation();
    test_gate_align();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
